// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM port arbiter.
// FSM encoding, master indices, lock-counter width, saturating helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    localparam int LOCK_W = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: combinational two-way round-robin picker.
// A tie goes to the master that was not granted last.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_idx
);

    // pick the single requester, or the one not served last on a tie
    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = M_CPU;
        unique case (1'b1)
            (req0 && req1):  grant_idx = ~last;
            (req1 && !req0): grant_idx = M_DBG;
            default:         grant_idx = M_CPU;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one registered-read RAM port between CPU and debug.
// Define RAM_ARBITER_STATS_EN to add grant and conflict counters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ram_wr_sig,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wr_data,
    input  logic [DW-1:0] ram_rd_data
`ifdef RAM_ARBITER_STATS_EN
   ,output logic [31:0]   grant_cnt0,
    output logic [31:0]   grant_cnt1,
    output logic [31:0]   conflict_cnt
`endif
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                hold_q, hold_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic                gnt_valid, gnt_idx;
    logic                req_own, req_oth, we_own, lock_own, lock_ok;
    logic [AW-1:0]       addr_own;
    logic [DW-1:0]       wdata_own;

    logic                wr_c, done_c, rsp_c;
    logic [AW-1:0]       addr_c;
    logic [DW-1:0]       wdata_c;

    ram_arb_rr u_rr (
        .req0        (req0),
        .req1        (req1),
        .last        (last_q),
        .grant_valid (gnt_valid),
        .grant_idx   (gnt_idx)
    );

    assign req_own   = (owner_q == M_DBG) ? req1   : req0;
    assign req_oth   = (owner_q == M_DBG) ? req0   : req1;
    assign we_own    = (owner_q == M_DBG) ? we1    : we0;
    assign lock_own  = (owner_q == M_DBG) ? lock1  : lock0;
    assign addr_own  = (owner_q == M_DBG) ? addr1  : addr0;
    assign wdata_own = (owner_q == M_DBG) ? wdata1 : wdata0;

    // ownership may be kept only while the lock budget is not spent
    assign lock_ok = lock_own && (lock_cnt_q < LOCK_W'(MAX_LOCK));

    // state, ownership and lock bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= M_CPU;
            last_q     <= M_DBG;
            hold_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // next state and RAM port drive
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_d     = hold_q;
        lock_cnt_d = lock_cnt_q;
        wr_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        done_c     = 1'b0;
        rsp_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                hold_d     = 1'b0;
                lock_cnt_d = '0;
                if (gnt_valid) begin
                    owner_d = gnt_idx;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                    if (req_own) begin
                        if (req_oth) begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                    end
                end else if (we_own) begin
                    wr_c    = 1'b1;
                    addr_c  = addr_own;
                    wdata_c = wdata_own;
                    done_c  = 1'b1;
                    if (lock_ok) begin
                        hold_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                    end
                end else begin
                    addr_c  = addr_own;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                done_c = 1'b1;
                rsp_c  = 1'b1;
                if (lock_ok) begin
                    state_d = ACCESS;
                    hold_d  = 1'b1;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (done_c) begin
            last_d = owner_q;
        end
    end

    assign ack0 = done_c & (owner_q == M_CPU) & ~reset;
    assign ack1 = done_c & (owner_q == M_DBG) & ~reset;

    assign rdata0 = (rsp_c && owner_q == M_CPU && !reset) ? ram_rd_data : '0;
    assign rdata1 = (rsp_c && owner_q == M_DBG && !reset) ? ram_rd_data : '0;

    assign ram_wr_sig  = wr_c & ~reset;
    assign ram_addr    = reset ? '0 : addr_c;
    assign ram_wr_data = reset ? '0 : wdata_c;

`ifdef RAM_ARBITER_STATS_EN
    logic [31:0] gcnt0_q, gcnt1_q, ccnt_q;

    // saturating completion and tie counters
    always_ff @(posedge clk) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            ccnt_q  <= '0;
        end else begin
            if (ack0) gcnt0_q <= sat_inc(gcnt0_q);
            if (ack1) gcnt1_q <= sat_inc(gcnt1_q);
            if (state_q == IDLE && req0 && req1) begin
                ccnt_q <= sat_inc(ccnt_q);
            end
        end
    end

    assign grant_cnt0   = gcnt0_q;
    assign grant_cnt1   = gcnt1_q;
    assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with MAX_LOCK=2.
// Expected acks are queued at stimulus time and matched against a monitor.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        ram_wr_sig;
    logic [31:0] ram_addr, ram_wr_data;
    logic [31:0] ram_rd_data;
`ifdef RAM_ARBITER_STATS_EN
    logic [31:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int both_ack = 0;
    int wr_in_reset = 0;

    typedef struct {
        int          m;
        logic [31:0] d;
        int          c;
        bit          rd;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    logic [31:0] mem [0:255];

    ram_arbiter #(.AW(32), .DW(32), .MAX_LOCK(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .lock0       (lock0),
        .lock1       (lock1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .ram_wr_sig  (ram_wr_sig),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
`ifdef RAM_ARBITER_STATS_EN
       ,.grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_wr_sig) mem[ram_addr[7:0]] <= ram_wr_data;
        ram_rd_data <= mem[ram_addr[7:0]];
    end

    always @(negedge clk) begin
        if (ack0 && ack1) both_ack++;
        if (reset && ram_wr_sig) wr_in_reset++;
        if (ack0) obs_q.push_back('{0, rdata0, cyc, 1'b0});
        if (ack1) obs_q.push_back('{1, rdata1, cyc, 1'b0});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    task automatic set_m(input int m, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit lk);
        if (m == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = lk;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = lk;
        end
    endtask

    task automatic wait_ack(input int m, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((m == 0 && ack0) || (m == 1 && ack1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_master(input int m, input int n, input bit we,
                              input bit lk, input logic [31:0] abase,
                              input logic [31:0] dbase, output int tmo);
        bit ok;
        tmo = 0;
        for (int k = 0; k < n; k++) begin
            set_m(m, 1'b1, we, abase + k, dbase + k, lk);
            wait_ack(m, ok);
            if (!ok) tmo++;
            @(posedge clk);
            #1;
        end
        set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        set_m(0, 1'b1, 1'b1, 32'h5, 32'h77, 1'b0);
        set_m(1, 1'b1, 1'b0, 32'h6, 32'h0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_ack: got %b%b want 00", ack0, ack1);
        end
        tests_run++;
        if (ram_wr_sig !== 1'b0) begin
            fails++;
            $display("FAIL reset_wr: got %b want 0", ram_wr_sig);
        end
        tests_run++;
        if (ram_addr !== 32'h0 || ram_wr_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_port: got %h/%h want 0/0",
                     ram_addr, ram_wr_data);
        end
        tests_run++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1);
        end
`ifdef RAM_ARBITER_STATS_EN
        tests_run++;
        if (grant_cnt0 !== 0 || grant_cnt1 !== 0 || conflict_cnt !== 0) begin
            fails++;
            $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0",
                     grant_cnt0, grant_cnt1, conflict_cnt);
        end
`endif
        do_reset();
    endtask

    task automatic test_lone();
        int n, t;
        ev_t e, o;
        do_reset();
        n = cyc;
        exp_q.push_back('{0, 32'h0, n + 1, 1'b0});
        run_master(0, 1, 1'b1, 1'b0, 32'd4, 32'h55, t);
        n = cyc;
        exp_q.push_back('{0, 32'h55, n + 2, 1'b1});
        run_master(0, 1, 1'b0, 1'b0, 32'd4, 32'h0, t);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL lone: got no ack, want m%0d @%0d", e.m, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.c !== e.c || (e.rd && o.d !== e.d)) begin
                    fails++;
                    $display("FAIL lone: got m%0d @%0d d=%h want m%0d @%0d d=%h",
                             o.m, o.c, o.d, e.m, e.c, e.d);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL lone_extra: got %0d extra acks want 0", obs_q.size());
        end
    endtask

    task automatic test_round_robin();
        int n, t0, t1;
        ev_t e, o;
        do_reset();
        n = cyc;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back('{k % 2, 32'h0, n + 1 + 2 * k, 1'b0});
        end
        fork
            run_master(0, 3, 1'b1, 1'b0, 32'h20, 32'hA000, t0);
            run_master(1, 3, 1'b1, 1'b0, 32'h30, 32'hB000, t1);
        join
        tests_run++;
        if (t0 + t1 != 0) begin
            fails++;
            $display("FAIL rr_timeout: got %0d timeouts want 0", t0 + t1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL rr: got no ack, want m%0d @%0d", e.m, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.c !== e.c) begin
                    fails++;
                    $display("FAIL rr: got m%0d @%0d want m%0d @%0d",
                             o.m, o.c, e.m, e.c);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL rr_extra: got %0d extra acks want 0", obs_q.size());
        end
        tests_run++;
        if (mem[8'h22] !== 32'hA002 || mem[8'h31] !== 32'hB001) begin
            fails++;
            $display("FAIL rr_mem: got %h/%h want a002/b001",
                     mem[8'h22], mem[8'h31]);
        end
`ifdef RAM_ARBITER_STATS_EN
        tests_run++;
        if (grant_cnt0 !== 3 || grant_cnt1 !== 3 || conflict_cnt !== 5) begin
            fails++;
            $display("FAIL rr_stats: got %0d/%0d/%0d want 3/3/5",
                     grant_cnt0, grant_cnt1, conflict_cnt);
        end
`endif
    endtask

    task automatic test_tie();
        int n, t0, t1;
        ev_t e, o;
        do_reset();
        n = cyc;
        exp_q.push_back('{0, 32'h55, n + 2, 1'b1});
        exp_q.push_back('{1, 32'hB001, n + 5, 1'b1});
        fork
            run_master(0, 1, 1'b0, 1'b0, 32'd4, 32'h0, t0);
            run_master(1, 1, 1'b0, 1'b0, 32'h31, 32'h0, t1);
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL tie: got no ack, want m%0d @%0d", e.m, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.c !== e.c || o.d !== e.d) begin
                    fails++;
                    $display("FAIL tie: got m%0d @%0d d=%h want m%0d @%0d d=%h",
                             o.m, o.c, o.d, e.m, e.c, e.d);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0 || t0 + t1 != 0) begin
            fails++;
            $display("FAIL tie_extra: got %0d extra/%0d timeouts want 0/0",
                     obs_q.size(), t0 + t1);
        end
    endtask

    task automatic test_lock();
        int n, t0, t1;
        ev_t e, o;
        do_reset();
        n = cyc;
        exp_q.push_back('{1, 32'h0, n + 1, 1'b0});
        exp_q.push_back('{1, 32'h0, n + 3, 1'b0});
        exp_q.push_back('{1, 32'h0, n + 5, 1'b0});
        exp_q.push_back('{0, 32'h0, n + 7, 1'b0});
        exp_q.push_back('{1, 32'h0, n + 9, 1'b0});
        fork
            run_master(1, 4, 1'b1, 1'b1, 32'h40, 32'hC000, t1);
            begin
                @(posedge clk);
                #1;
                run_master(0, 1, 1'b1, 1'b0, 32'h50, 32'hD000, t0);
            end
        join
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL lock: got no ack, want m%0d @%0d", e.m, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.c !== e.c) begin
                    fails++;
                    $display("FAIL lock: got m%0d @%0d want m%0d @%0d",
                             o.m, o.c, e.m, e.c);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0 || t0 + t1 != 0) begin
            fails++;
            $display("FAIL lock_extra: got %0d extra/%0d timeouts want 0/0",
                     obs_q.size(), t0 + t1);
        end
    endtask

    task automatic test_lock_idle();
        int n, t;
        ev_t e, o;
        do_reset();
        n = cyc;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back('{1, 32'h0, n + 1 + 2 * k, 1'b0});
        end
        run_master(1, 6, 1'b1, 1'b1, 32'h60, 32'hE000, t);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL lock_idle: got no ack, want m%0d @%0d", e.m, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.c !== e.c) begin
                    fails++;
                    $display("FAIL lock_idle: got m%0d @%0d want m%0d @%0d",
                             o.m, o.c, e.m, e.c);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0 || t != 0) begin
            fails++;
            $display("FAIL lock_idle_extra: got %0d extra/%0d timeouts want 0/0",
                     obs_q.size(), t);
        end
        tests_run++;
        if (mem[8'h65] !== 32'hE005) begin
            fails++;
            $display("FAIL lock_idle_mem: got %h want e005", mem[8'h65]);
        end
    endtask

    task automatic test_reset_in_access();
        int n, t;
        ev_t e, o;
        do_reset();
        n = cyc;
        exp_q.push_back('{0, 32'h0, n + 1, 1'b0});
        run_master(0, 1, 1'b1, 1'b0, 32'd8, 32'h1234, t);
        set_m(0, 1'b1, 1'b1, 32'd8, 32'hDEAD, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ram_wr_sig !== 1'b0 || ack0 !== 1'b0) begin
            fails++;
            $display("FAIL rst_access: got wr=%b ack=%b want 0/0",
                     ram_wr_sig, ack0);
        end
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n = cyc;
        exp_q.push_back('{0, 32'h1234, n + 2, 1'b1});
        run_master(0, 1, 1'b0, 1'b0, 32'd8, 32'h0, t);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL rst_seq: got no ack, want m%0d @%0d", e.m, e.c);
            end else begin
                o = obs_q.pop_front();
                if (o.m !== e.m || o.c !== e.c || (e.rd && o.d !== e.d)) begin
                    fails++;
                    $display("FAIL rst_seq: got m%0d @%0d d=%h want m%0d @%0d d=%h",
                             o.m, o.c, o.d, e.m, e.c, e.d);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL rst_extra: got %0d extra acks want 0", obs_q.size());
        end
        tests_run++;
        if (mem[8'h08] !== 32'h1234) begin
            fails++;
            $display("FAIL rst_mem: got %h want 1234", mem[8'h08]);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_lone();
        test_round_robin();
        test_tie();
        test_lock();
        test_lock_idle();
        test_reset_in_access();
        tests_run++;
        if (both_ack != 0) begin
            fails++;
            $display("FAIL dual_ack: got %0d cycles want 0", both_ack);
        end
        tests_run++;
        if (wr_in_reset != 0) begin
            fails++;
            $display("FAIL wr_in_reset: got %0d cycles want 0", wr_in_reset);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single data RAM port between two requesters: master 0 is the CPU data port (mem_addr/mem_wr_data/mem_wr_sig/mem_rd_data) and master 1 is a debug/loader port that preloads or inspects RAM while the CPU runs. It sits between the cpu and ram instances and drives ram's wr_sig, wr_data and addr. It arbitrates round-robin with an optional bounded lock, and it sequences each access against the RAM's one-cycle registered read latency.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_LOCK, 8, maximum consecutive locked accesses by one master while the other master requests; range 1..255
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; addr, we, wdata and lock held stable until the matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- lock0 / lock1  in  1  keep ownership for the next access
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data, valid while ack is high for a read
- ram_wr_sig  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wr_data  out  DW  RAM write data
- ram_rd_data  in  DW  RAM read data, registered, valid one cycle after ram_addr

## Operation
- State machine: IDLE, ACCESS, RESPOND; `owner` register (0/1); `last` register holds the last granted master.
- IDLE:
  - Exactly one req high: grant that master.
  - Both high: grant !last.
  - The grant registers owner and moves the FSM to ACCESS.
- ACCESS: RAM port is muxed to the owner.
  - Write: ram_wr_sig=1 and ack_owner=1 this cycle. Next state is ACCESS if the lock rule holds, otherwise IDLE.
  - Read: ram_wr_sig=0. Next state is RESPOND.
- RESPOND: ack_owner=1 and rdata_owner=ram_rd_data. Next state follows the same lock rule as a write.
- Lock rule: ownership is retained only if all of the following hold. Otherwise the next state is IDLE.
  - lock_owner=1 at completion.
  - req_owner is asserted again in the cycle after ack.
  - lock_cnt < MAX_LOCK.
- Retention check: the FSM sits one cycle in a hold sub-step of ACCESS with the RAM port idle.
  - If req_owner is high, the access proceeds.
  - If req_owner is low, the FSM returns to IDLE.
- lock_cnt:
  - Increments per retained access while the other req is high.
  - Clears on any ownership change and on entry to IDLE.
- On completion, last is updated to owner.
- Idle RAM drive (IDLE, RESPOND, hold): ram_wr_sig=0, ram_addr=0, ram_wr_data=0.
- rdata0/rdata1 are 0 when the matching ack is low.
- req dropped before ack:
  - In ACCESS, the access still completes (write committed, ack issued).
  - If req was dropped while the FSM was in IDLE, no grant is made.

## Timing
- Reset values: FSM=IDLE, owner=0, last=1 (master 0 wins the first tie), lock_cnt=0, all outputs 0.
- While reset=1, ram_wr_sig is forced to 0 combinationally. An in-flight access is abandoned with no ack.
- Write latency: req seen in IDLE at cycle N, then ACCESS and ack at N+1.
- Read latency: req at N, ACCESS at N+1, RESPOND with ack and rdata at N+2.
- Minimum request-to-request turnaround per master:
  - Without lock: 1 IDLE cycle after ack.
  - With lock: 1 hold cycle after ack.
- Simultaneous requests: never both acks in one cycle; the loser is served immediately after the winner's IDLE cycle.
- Starvation bound: a waiting master is granted within (MAX_LOCK+1) × 3 + 1 cycles.

## Configuration
- RAM_ARBITER_STATS_EN defined adds three outputs:
  - grant_cnt0 (32 bits): per-master completed-access count.
  - grant_cnt1 (32 bits): per-master completed-access count.
  - conflict_cnt (32 bits): IDLE cycles with both req high.
- All three counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package ram_arb_pkg holds:
  - the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2);
  - master index constants M_CPU=0, M_DBG=1;
  - the lock-counter width (8).
- Sub-module ram_arb_rr: a combinational two-way round-robin picker. It takes req0, req1 and last, and returns grant_valid and grant_idx.

## Test plan
- Lone writes: CPU write addr 4, data 0x55, then a lone read of addr 4 → ack0 at N+1 for the write; ack0 at N+2 for the read, rdata0=0x55; ack1 never asserted.
- Tie after reset: both masters request reads in the same cycle → master 0 is granted first; master 1's ack is 3 cycles after master 0's ack.
- Round robin: both masters hold req for 6 accesses → acks alternate 0,1,0,1,0,1.
- Lock with MAX_LOCK=2:
  - master 1 requests locked writes while master 0 requests → master 1 completes exactly 3 consecutive accesses, then master 0 is granted;
  - with master 0 idle, master 1 keeps ownership indefinitely.
- Reset in ACCESS of a write to addr 8 → ram_wr_sig stays 0, no ack, RAM addr 8 unchanged; FSM is IDLE after release.
- With RAM_ARBITER_STATS_EN: run the round-robin test → grant_cnt0=3, grant_cnt1=3, and conflict_cnt equals the number of tied IDLE cycles.
